// File: rtl/cdb_rr_arbiter.sv
// Registered round-robin CDB arbiter: one of ALU/LSM/BRA wins per cycle and is broadcast the next cycle.
// Define CDB_BRA_PRIORITY_EN to give BRA absolute priority, with round-robin kept between ALU and LSM.
module cdb_rr_arbiter #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NO_LOCK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              alu_req,
    output logic              alu_grnt,
    input  logic [IDX_W-1:0]  alu_in_index,
    input  logic [DATA_W-1:0] alu_in_data,
    input  logic              lsm_req,
    output logic              lsm_grnt,
    input  logic [IDX_W-1:0]  lsm_in_index,
    input  logic [DATA_W-1:0] lsm_in_data,
    input  logic [ADDR_W-1:0] lsm_in_addr,
    input  logic              bra_req,
    output logic              bra_grnt,
    input  logic [IDX_W-1:0]  bra_in_index,
    input  logic [DATA_W-1:0] bra_in_data,
    output logic              out_valid,
    output logic [1:0]        out_src,
    output logic              out_is_branch,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSM  = 2'd2,
        SRC_BRA  = 2'd3
    } src_e;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } payload_t;

    localparam logic [IDX_W-1:0] NO_LOCK_IDX = IDX_W'(NO_LOCK);

    src_e     ptr;
    src_e     win;
    payload_t sel;
    logic     blocked;

    assign blocked = rst | flush | hold;

    always_comb begin
        win = SRC_NONE;
        if (!blocked) begin
`ifdef CDB_BRA_PRIORITY_EN
            if (bra_req)
                win = SRC_BRA;
            else if (ptr == SRC_LSM)
                win = lsm_req ? SRC_LSM : (alu_req ? SRC_ALU : SRC_NONE);
            else
                win = alu_req ? SRC_ALU : (lsm_req ? SRC_LSM : SRC_NONE);
`else
            unique case (ptr)
                SRC_LSM: win = lsm_req ? SRC_LSM : bra_req ? SRC_BRA : alu_req ? SRC_ALU : SRC_NONE;
                SRC_BRA: win = bra_req ? SRC_BRA : alu_req ? SRC_ALU : lsm_req ? SRC_LSM : SRC_NONE;
                default: win = alu_req ? SRC_ALU : lsm_req ? SRC_LSM : bra_req ? SRC_BRA : SRC_NONE;
            endcase
`endif
        end
    end

    assign alu_grnt = (win == SRC_ALU);
    assign lsm_grnt = (win == SRC_LSM);
    assign bra_grnt = (win == SRC_BRA);

    // Only the LSM carries an address; everything else broadcasts zero there.
    always_comb begin
        sel = '0;
        unique case (win)
            SRC_ALU: sel = '{index: alu_in_index, data: alu_in_data, addr: '0};
            SRC_LSM: sel = '{index: lsm_in_index, data: lsm_in_data, addr: lsm_in_addr};
            SRC_BRA: sel = '{index: bra_in_index, data: bra_in_data, addr: '0};
            default: sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= SRC_ALU;
            out_valid     <= 1'b0;
            out_src       <= SRC_NONE;
            out_is_branch <= 1'b0;
            out_index     <= NO_LOCK_IDX;
            out_data      <= '0;
            out_addr      <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_src       <= SRC_NONE;
            out_is_branch <= 1'b0;
            out_index     <= NO_LOCK_IDX;
        end else if (!hold) begin
            if (win != SRC_NONE) begin
                out_valid     <= 1'b1;
                out_src       <= win;
                out_is_branch <= (win == SRC_BRA);
                out_index     <= sel.index;
                out_data      <= sel.data;
                out_addr      <= sel.addr;
`ifdef CDB_BRA_PRIORITY_EN
                // BRA bypasses the rotation, so only ALU/LSM grants move the pointer.
                if (win == SRC_ALU)
                    ptr <= SRC_LSM;
                else if (win == SRC_LSM)
                    ptr <= SRC_ALU;
`else
                unique case (win)
                    SRC_ALU: ptr <= SRC_LSM;
                    SRC_LSM: ptr <= SRC_BRA;
                    default: ptr <= SRC_ALU;
                endcase
`endif
            end else begin
                out_valid     <= 1'b0;
                out_src       <= SRC_NONE;
                out_is_branch <= 1'b0;
                out_index     <= NO_LOCK_IDX;
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter (default build): grants, rotation, hold, flush and reset.
module tb_cdb_rr_arbiter;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst, flush, hold;
    logic              alu_req, lsm_req, bra_req;
    logic              alu_grnt, lsm_grnt, bra_grnt;
    logic [IDX_W-1:0]  alu_in_index, lsm_in_index, bra_in_index;
    logic [DATA_W-1:0] alu_in_data, lsm_in_data, bra_in_data;
    logic [ADDR_W-1:0] lsm_in_addr;
    logic              out_valid, out_is_branch;
    logic [1:0]        out_src;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    int checks   = 0;
    int failures = 0;

    cdb_rr_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NO_LOCK(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .alu_req(alu_req), .alu_grnt(alu_grnt), .alu_in_index(alu_in_index), .alu_in_data(alu_in_data),
        .lsm_req(lsm_req), .lsm_grnt(lsm_grnt), .lsm_in_index(lsm_in_index), .lsm_in_data(lsm_in_data),
        .lsm_in_addr(lsm_in_addr),
        .bra_req(bra_req), .bra_grnt(bra_grnt), .bra_in_index(bra_in_index), .bra_in_data(bra_in_data),
        .out_valid(out_valid), .out_src(out_src), .out_is_branch(out_is_branch),
        .out_index(out_index), .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp [6];

    initial begin
        rr_exp = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        rst = 1; flush = 0; hold = 0;
        alu_req = 0; lsm_req = 0; bra_req = 0;
        alu_in_index = 0; lsm_in_index = 0; bra_in_index = 0;
        alu_in_data = 0; lsm_in_data = 0; bra_in_data = 0; lsm_in_addr = 0;
        step(); step();

        // Reset state; a request during reset is not granted.
        alu_req = 1; #1;
        chk("rst_grnt", {alu_grnt, lsm_grnt, bra_grnt}, 3'b000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_index", out_index, 5'd0);
        chk("rst_src", out_src, 2'd0);
        chk("rst_data", out_data, 32'h0);

        // Single ALU result
        rst = 0; alu_in_index = 5; alu_in_data = 32'h1234; #1;
        chk("alu_grnt", {alu_grnt, lsm_grnt, bra_grnt}, 3'b100);
        step();
        alu_req = 0;
        chk("alu_valid", out_valid, 1'b1);
        chk("alu_src", out_src, 2'd1);
        chk("alu_index", out_index, 5'd5);
        chk("alu_data", out_data, 32'h1234);
        chk("alu_addr", out_addr, 32'h0);

        // No requests: broadcast clears, data holds
        step();
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_index", out_index, 5'd0);
        chk("idle_src", out_src, 2'd0);
        chk("idle_data_hold", out_data, 32'h1234);

        // Three-way rotation from reset
        rst = 1; step(); rst = 0;
        alu_req = 1; lsm_req = 1; bra_req = 1;
        alu_in_index = 1; lsm_in_index = 2; bra_in_index = 3;
        alu_in_data = 32'hA; lsm_in_data = 32'hB; bra_in_data = 32'hC; lsm_in_addr = 32'h44;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_grnt%0d", i), {alu_grnt, lsm_grnt, bra_grnt},
                {rr_exp[i] == 2'd1, rr_exp[i] == 2'd2, rr_exp[i] == 2'd3});
            step();
            chk($sformatf("rr_src%0d", i), out_src, rr_exp[i]);
            chk($sformatf("rr_br%0d", i), out_is_branch, rr_exp[i] == 2'd3);
            chk($sformatf("rr_idx%0d", i), out_index, {3'b0, rr_exp[i]});
        end
        alu_req = 0; lsm_req = 0; bra_req = 0;
        step();

        // Hold blocks grants for 3 cycles, then LSM goes through
        lsm_req = 1; lsm_in_addr = 32'h80; lsm_in_index = 3; lsm_in_data = 32'h55; hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold_grnt%0d", i), lsm_grnt, 1'b0);
            step();
            chk($sformatf("hold_valid%0d", i), out_valid, 1'b0);
        end
        hold = 0; #1;
        chk("lsm_grnt", lsm_grnt, 1'b1);
        step();
        lsm_req = 0;
        chk("lsm_addr", out_addr, 32'h80);
        chk("lsm_index", out_index, 5'd3);
        chk("lsm_src", out_src, 2'd2);

        // Hold keeps a valid broadcast visible
        hold = 1; step();
        chk("hold_keep_valid", out_valid, 1'b1);
        chk("hold_keep_index", out_index, 5'd3);
        hold = 0;

        // Flush kills broadcast and blocks BRA; pointer stays at BRA
        flush = 1; bra_req = 1; bra_in_index = 7; bra_in_data = 32'hBEEF; #1;
        chk("flush_grnt", bra_grnt, 1'b0);
        step();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_index", out_index, 5'd0);
        flush = 0; alu_req = 1; alu_in_index = 9; alu_in_data = 32'h99; #1;
        chk("ptr_kept_grnt", {alu_grnt, lsm_grnt, bra_grnt}, 3'b001);
        step();
        bra_req = 0;
        chk("bra_src", out_src, 2'd3);
        chk("bra_br", out_is_branch, 1'b1);
        chk("bra_data", out_data, 32'hBEEF);
        chk("bra_addr", out_addr, 32'h0);
        #1;
        chk("alu_after_bra", alu_grnt, 1'b1);
        step();
        alu_req = 0;
        chk("alu2_index", out_index, 5'd9);

        // Flush wins over hold
        hold = 1; flush = 1; step();
        chk("flush_over_hold", out_valid, 1'b0);
        hold = 0; flush = 0;

        // Reset mid-broadcast
        lsm_req = 1; step(); lsm_req = 0;
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1; step();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_addr", out_addr, 32'h0);
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Registered round-robin arbiter and broadcast stage for the common data bus.
- Shares one CDB slot per cycle between the three result producers (ALU, LSM, BRA). Latches the winner's result into output registers and broadcasts it one cycle later to the RS, ROB, PC and LSM consumers.
- Replaces fixed-priority selection so no producer can be starved. Adds a downstream hold and a pipeline flush.

Parameters:
- IDX_W, 5, width of the ROB/register-lock tag.
- DATA_W, 32, width of the result data.
- ADDR_W, 32, width of the LSM address field.
- NO_LOCK, 0, tag value meaning "no valid broadcast".

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  mispredict flush: kill the current broadcast and block grants.
- hold  in  1  downstream back-pressure: freeze the output registers and block grants.
- alu_req  in  1  ALU has a result pending.
- alu_grnt  out  1  ALU result accepted this cycle.
- alu_in_index  in  IDX_W  ALU result tag.
- alu_in_data  in  DATA_W  ALU result data.
- lsm_req  in  1  LSM has a result pending.
- lsm_grnt  out  1  LSM result accepted this cycle.
- lsm_in_index  in  IDX_W  LSM result tag.
- lsm_in_data  in  DATA_W  LSM result data.
- lsm_in_addr  in  ADDR_W  LSM effective address.
- bra_req  in  1  branch unit has a result pending.
- bra_grnt  out  1  branch result accepted this cycle.
- bra_in_index  in  IDX_W  branch result tag.
- bra_in_data  in  DATA_W  branch target/result.
- out_valid  out  1  broadcast valid.
- out_src  out  2  broadcast source: 1=ALU, 2=LSM, 3=BRA, 0=none.
- out_is_branch  out  1  broadcast came from BRA.
- out_index  out  IDX_W  broadcast tag; NO_LOCK when not valid.
- out_data  out  DATA_W  broadcast data.
- out_addr  out  ADDR_W  broadcast address (LSM only, else 0).

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset rst.

Grant generation (combinational):
- At most one grnt is high per cycle, and only when its req is high.
- All grnts are 0 while rst, flush or hold is high.

Round-robin pointer:
- 2-bit register ptr holding ALU, LSM or BRA. Reset value is ALU.
- Search order starts at ptr: ALU->LSM->BRA, LSM->BRA->ALU, or BRA->ALU->LSM. The first requester in that order wins.
- After a grant to X, ptr becomes the successor of X (ALU->LSM->BRA->ALU).
- With no grant, ptr is unchanged.

Requester contract:
- A requester holds req, index, data and addr stable until it sees grnt high in a cycle.
- It may drop req, or present a new result, in the cycle after that grant.
- A grant is a completed transfer. The arbiter never re-grants the same payload.

Output registers (updated on rising clk):
- rst: out_valid=0, out_src=0, out_is_branch=0, out_index=NO_LOCK, out_data=0, out_addr=0, ptr=ALU.
- else flush: out_valid=0, out_src=0, out_is_branch=0, out_index=NO_LOCK. Data and address are don't-care but held. Flush wins over hold.
- else hold: all outputs and ptr keep their values. A valid broadcast stays visible until hold drops.
- else on a grant: out_valid=1, out_src=winner, out_index/out_data=winner payload, out_is_branch=(winner==BRA), out_addr=lsm_in_addr if LSM else 0.
- else (no request): out_valid=0, out_src=0, out_is_branch=0, out_index=NO_LOCK. Data and address hold.

Timing:
- Latency is 1 cycle from grant to broadcast.
- Throughput is 1 broadcast per cycle when hold=0.
- A producer requesting continuously waits at most 2 cycles for a grant while hold=0 and flush=0.

Boundary conditions:
- Simultaneous flush and req: no grant; the requester keeps req asserted.
- rst asserted mid-broadcast: the broadcast is cleared on the next edge.

Optional Feature:
- Macro: CDB_BRA_PRIORITY_EN.
- When defined: a bra_req always wins over ALU and LSM regardless of ptr, and ptr is not updated by BRA grants. Round-robin applies between ALU and LSM only. This shortens mispredict recovery.
- When undefined: strict 3-way round-robin as described above.

Test Plan:
- Reset, then alu_req=1 with index=5, data=0x1234 -> alu_grnt=1 in that cycle. Next cycle out_valid=1, out_src=1, out_index=5, out_data=0x1234, out_addr=0.
- All three req held high for 6 cycles from reset -> grant order ALU, LSM, BRA, ALU, LSM, BRA. out_is_branch=1 exactly on the BRA broadcasts.
- lsm_req with addr=0x80, index=3, hold=1 for 3 cycles -> lsm_grnt=0 throughout. After hold drops: grant, then out_addr=0x80 and out_index=3.
- Broadcast valid with flush=1 and bra_req=1 -> next cycle out_valid=0, out_index=NO_LOCK, bra_grnt=0. ptr unchanged.
- No requests after a broadcast -> next cycle out_valid=0, out_index=NO_LOCK, out_src=0.
- With CDB_BRA_PRIORITY_EN and all req high -> BRA granted every cycle. Once bra_req drops, ALU and LSM alternate.
